// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift scheduler: shift mode encoding, FSM
// state encoding, the widest single pass the shifter supports, and small
// mode-classification helpers used by the controller.
package shift_sched_pkg;

  // Largest shift the datapath performs in one pass.
  localparam int MAX_STEP = 3;

  // Command mode encoding; 3'b111 is also treated as pass-through.
  typedef enum logic [2:0] {
    MODE_LSL  = 3'b000,
    MODE_LSR  = 3'b001,
    MODE_ASL  = 3'b010,
    MODE_ASR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_PASS = 3'b110
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  // True for every mode that actually moves bits (LSL..ROR).
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode <= 3'b101);
  endfunction

  // True for the two rotate modes.
  function automatic logic is_rotate_mode(input logic [2:0] mode);
    return (mode == 3'b100) || (mode == 3'b101);
  endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational 4-bit barrel shifter performing one pass of 0..3 bits.
// Ports:
//   data_i  4-bit operand
//   amt_i   pass shift amount (0..3)
//   mode_i  shift mode (LSL/LSR/ASL/ASR/ROL/ROR, 11x = pass-through)
//   data_o  shifted result
module barrel_shift_core
  import shift_sched_pkg::*;
(
  input  logic [3:0] data_i,
  input  logic [1:0] amt_i,
  input  logic [2:0] mode_i,
  output logic [3:0] data_o
);

  logic [7:0] rot_l_s;
  logic [7:0] rot_r_s;

  // One shift pass selected by mode; rotates use a doubled operand so the
  // wrapped bits fall into the kept nibble.
  always_comb begin
    rot_l_s = {data_i, data_i} << amt_i;
    rot_r_s = {data_i, data_i} >> amt_i;
    data_o  = data_i;
    case (mode_i)
      MODE_LSL, MODE_ASL: data_o = data_i << amt_i;
      MODE_LSR:           data_o = data_i >> amt_i;
      MODE_ASR:           data_o = $signed(data_i) >>> amt_i;
      MODE_ROL:           data_o = rot_l_s[7:4];
      MODE_ROR:           data_o = rot_r_s[3:0];
      default:            data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sched_ctrl.sv
// Round-robin scheduler that shares one 4-bit barrel shifter between
// NUM_REQ requesters. A total shift of 0..15 is executed as repeated passes
// of at most MAX_STEP bits; the result is returned tagged with the id of the
// requester that issued it.
//
// Optional feature (macro SHIFT_SCHED_ROT_SHORTCUT_EN):
//   defined     - ROL/ROR amounts are reduced mod 4 at accept, so a rotate
//                 needs at most one pass (multiples of 4 answer directly).
//   not defined - rotates are sequenced like the other modes.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   req_valid   per-requester command valid
//   req_ready   per-requester accept, one-hot or zero, only while idle
//   req_data    4-bit operand per requester
//   req_amt     total shift amount per requester
//   req_mode    3-bit mode per requester
//   rsp_valid   result valid, held until rsp_ready
//   rsp_ready   result consumer ready
//   rsp_data    shifted result
//   rsp_id      id of the requester owning rsp_data
//   busy        high whenever the FSM is not idle
module shift_sched_ctrl
  import shift_sched_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int AMT_W   = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*4-1:0]     req_data,
  input  logic [NUM_REQ*AMT_W-1:0] req_amt,
  input  logic [NUM_REQ*3-1:0]     req_mode,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [3:0]               rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [3:0]        work_q, work_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic [2:0]        mode_q, mode_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              grant_found_s;
  int                grant_idx_s;
  int                scan_idx_s;
  logic [3:0]        sel_data_s;
  logic [AMT_W-1:0]  sel_amt_s;
  logic [2:0]        sel_mode_s;
  logic [AMT_W-1:0]  eff_amt_s;
  logic [1:0]        step_s;
  logic [3:0]        shifted_s;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 0;
    scan_idx_s    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx_s = int'(ptr_q) + k;
      if (scan_idx_s >= NUM_REQ) begin
        scan_idx_s = scan_idx_s - NUM_REQ;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!grant_found_s && req_valid[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Command fields of the granted requester.
  always_comb begin
    sel_data_s = req_data[4*grant_idx_s +: 4];
    sel_amt_s  = req_amt[AMT_W*grant_idx_s +: AMT_W];
    sel_mode_s = req_mode[3*grant_idx_s +: 3];
  end

  // Amount actually sequenced; rotates may be folded to a single pass.
  always_comb begin
    eff_amt_s = sel_amt_s;
`ifdef SHIFT_SCHED_ROT_SHORTCUT_EN
    if (is_rotate_mode(sel_mode_s)) begin
      eff_amt_s = AMT_W'(sel_amt_s[1:0]);
    end else begin
      eff_amt_s = sel_amt_s;
    end
`else
    eff_amt_s = sel_amt_s;
`endif
  end

  // Pass size: the whole remainder if it fits, otherwise a full step.
  always_comb begin
    if (rem_q >= AMT_W'(MAX_STEP)) begin
      step_s = 2'(MAX_STEP);
    end else begin
      step_s = rem_q[1:0];
    end
  end

  barrel_shift_core u_core (
    .data_i (work_q),
    .amt_i  (step_s),
    .mode_i (mode_q),
    .data_o (shifted_s)
  );

  // FSM next state, datapath register updates and accept strobes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    work_d    = work_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    id_d      = id_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready[grant_idx_s] = 1'b1;
          work_d = sel_data_s;
          mode_d = sel_mode_s;
          id_d   = ID_W'(grant_idx_s);
          rem_d  = eff_amt_s;
          // Nothing to shift: answer directly with the operand unchanged.
          if ((eff_amt_s != '0) && is_shift_mode(sel_mode_s)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shifted_s;
        rem_d  = rem_q - AMT_W'(step_s);
        // Leave on the same edge as the final pass.
        if (rem_q <= AMT_W'(MAX_STEP)) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          if (id_q == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = id_q + ID_W'(1);
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // No accept may be signalled while reset is applied.
    if (!rst_n) begin
      req_ready = '0;
    end else begin
      req_ready = req_ready;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      work_q  <= 4'b0000;
      rem_q   <= '0;
      mode_q  <= 3'b000;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = work_q;
  assign rsp_id    = id_q;

endmodule
